// File: rtl/pool_window_buffer_pkg.sv
// Shared definitions for the pooling front end.
//   DEFAULT_DATA_W : default pixel width (two's-complement signed)
//   pixel_t        : signed pixel at the default width
//   TL/TR/BL/BR    : window slot order, matching pooling-stage input1..input4
package pool_pkg;

  localparam int unsigned DEFAULT_DATA_W = 4;

  typedef logic signed [DEFAULT_DATA_W-1:0] pixel_t;

  localparam int unsigned TL        = 0;
  localparam int unsigned TR        = 1;
  localparam int unsigned BL        = 2;
  localparam int unsigned BR        = 3;
  localparam int unsigned NUM_SLOTS = 4;

endpackage

// File: rtl/pool_window_buffer_if.sv
// Pixel-in / window-out bundle between the convolution stage, the window
// buffer and the 2x2 max-pooling stage.
//   master : pixel producer (drives in_*, observes win_* / frame_done)
//   slave  : window buffer  (consumes in_*, drives win_* / frame_done)
interface pool_window_buffer_if #(
  parameter int unsigned DATA_W = pool_pkg::DEFAULT_DATA_W
);

  logic                     in_valid;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_data;
  logic                     win_valid;
  logic signed [DATA_W-1:0] win_tl;
  logic signed [DATA_W-1:0] win_tr;
  logic signed [DATA_W-1:0] win_bl;
  logic signed [DATA_W-1:0] win_br;
  logic                     frame_done;

  modport master (
    output in_valid, in_sof, in_data,
    input  win_valid, win_tl, win_tr, win_bl, win_br, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output win_valid, win_tl, win_tr, win_bl, win_br, frame_done
  );

endinterface

// File: rtl/pool_line_buffer.sv
// One-row pixel store for the window buffer.
//   clk   : rising-edge clock
//   we    : write enable, stores wdata at waddr on the clock edge
//   waddr : write column
//   wdata : pixel to store
//   raddr : read column
//   rdata : combinational read of the stored pixel at raddr
module pool_line_buffer #(
  parameter int unsigned DATA_W = pool_pkg::DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_buffer.sv
// Collects a raster-order pixel stream into non-overlapping 2x2 windows
// (stride 2) for the max-pooling stage. Even rows are parked in a line
// buffer; odd rows pair with them to form windows.
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   bus.in_*   : pixel stream (valid, start-of-frame, signed data)
//   bus.win_*  : registered window, one-cycle win_valid
//   bus.frame_done : one-cycle pulse alongside the last window of a frame
module pool_window_buffer #(
  parameter int unsigned DATA_W = pool_pkg::DEFAULT_DATA_W,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic                clk,
  input  logic                rst,
  pool_window_buffer_if.slave bus
);

  import pool_pkg::*;

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
    $error("pool_window_buffer: IMG_W must be even and at least 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
    $error("pool_window_buffer: IMG_H must be even and at least 2");
  end

  logic [COL_W-1:0] col, col_eff, col_nxt;
  logic [ROW_W-1:0] row, row_eff, row_nxt;
  logic             last_col, last_row;
  logic             odd_row, odd_col;
  logic             restart;

  // Set by the first start-of-frame after reset; a stream resumed after a
  // mid-frame reset must not be mistaken for a new frame.
  logic             armed;

  logic signed [DATA_W-1:0] tl_hold, bl_hold;
  logic        [DATA_W-1:0] lb_rdata;
  logic signed [DATA_W-1:0] win_q [NUM_SLOTS];
  logic                     win_valid_q, frame_done_q;

  // A start-of-frame pixel overrides the counters and is placed at (0,0).
  always_comb begin
    restart  = bus.in_valid && bus.in_sof;
    col_eff  = restart ? '0 : col;
    row_eff  = restart ? '0 : row;
    last_col = (col_eff == COL_W'(IMG_W - 1));
    last_row = (row_eff == ROW_W'(IMG_H - 1));
    odd_col  = col_eff[0];
    odd_row  = row_eff[0];
    col_nxt  = last_col ? '0 : col_eff + COL_W'(1);
    row_nxt  = row_eff;
    if (last_col) begin
      row_nxt = last_row ? '0 : row_eff + ROW_W'(1);
    end
  end

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (COL_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (bus.in_valid && !odd_row),
    .waddr (col_eff),
    .wdata (bus.in_data),
    .raddr (col_eff),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      armed        <= 1'b0;
      tl_hold      <= '0;
      bl_hold      <= '0;
      win_q        <= '{default: '0};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.in_valid) begin
        col <= col_nxt;
        row <= row_nxt;
        if (bus.in_sof) begin
          armed <= 1'b1;
        end
        if (odd_row && !odd_col) begin
          bl_hold <= bus.in_data;
          tl_hold <= lb_rdata;
        end
        if (odd_row && odd_col && armed) begin
          win_q[TL]    <= tl_hold;
          win_q[TR]    <= lb_rdata;
          win_q[BL]    <= bl_hold;
          win_q[BR]    <= bus.in_data;
          win_valid_q  <= 1'b1;
          frame_done_q <= last_row && last_col;
        end
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_tl     = win_q[TL];
  assign bus.win_tr     = win_q[TR];
  assign bus.win_bl     = win_q[BL];
  assign bus.win_br     = win_q[BR];

endmodule

// File: tb/tb_pool_window_buffer.sv
// Self-checking bench for pool_window_buffer on a 4x4 frame of 4-bit pixels.
// A frame-array reference model predicts every cycle's outputs.
module tb_pool_window_buffer;

  localparam int unsigned DW = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned VW = 2 + 4 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_window_buffer_if #(.DATA_W(DW)) bus ();

  pool_window_buffer #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          v;
    logic          sof;
    logic [DW-1:0] d;
  } stim_t;

  stim_t q[$];

  // Reference model: pixels land in a frame image at their raster position;
  // completing the bottom-right of a 2x2 block yields that block.
  logic [DW-1:0] pix [H][W];
  int unsigned   m_r, m_c;
  bit            m_armed;
  logic [DW-1:0] m_win [4];
  bit            m_valid, m_done;

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_done, m_win[0], m_win[1], m_win[2], m_win[3]};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {bus.win_valid, bus.frame_done, bus.win_tl, bus.win_tr, bus.win_bl, bus.win_br};
  endfunction

  task automatic model_reset();
    m_r = 0; m_c = 0; m_armed = 0; m_valid = 0; m_done = 0;
    for (int i = 0; i < 4; i++) m_win[i] = '0;
  endtask

  task automatic push(input bit v, input bit sof, input logic [DW-1:0] d);
    q.push_back('{v: v, sof: sof, d: d});
  endtask

  task automatic cycle(input logic v, input logic sof, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    m_valid = 0;
    m_done  = 0;
    if (v) begin
      if (sof) begin
        m_r = 0; m_c = 0; m_armed = 1;
      end
      pix[m_r][m_c] = d;
      if (m_armed && (m_r % 2 == 1) && (m_c % 2 == 1)) begin
        m_win[0] = pix[m_r-1][m_c-1];
        m_win[1] = pix[m_r-1][m_c];
        m_win[2] = pix[m_r][m_c-1];
        m_win[3] = pix[m_r][m_c];
        m_valid  = 1;
        m_done   = (m_r == H - 1) && (m_c == W - 1);
      end
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r + 1) % H;
      end
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [VW-1:0] zero;
    zero = '0;
    do_reset();
    n_tests++;
    if (got_vec() !== zero) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", got_vec(), zero);
    end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'($urandom), DW'($urandom));
      n_tests++;
      if (got_vec() !== zero) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got %h expected %h", k, got_vec(), zero);
      end
    end
  endtask

  task automatic test_continuous();
    int nwin = 0, ndone = 0, done_win = 0;
    int win_pix [4];
    int exp_pix [4] = '{5, 7, 13, 15};
    for (int i = 0; i < 16; i++) push(1'b1, i == 0, DW'(i));
    foreach (q[k]) begin
      cycle(q[k].v, q[k].sof, q[k].d);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL continuous cyc%0d: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (bus.win_valid === 1'b1) begin
        if (nwin < 4) win_pix[nwin] = k;
        nwin++;
      end
      if (bus.frame_done === 1'b1) begin
        ndone++;
        done_win = nwin;
      end
    end
    q.delete();
    n_tests++;
    if (nwin != 4 || ndone != 1 || done_win != 4) begin
      n_fail++;
      $display("FAIL continuous_counts: got win=%0d done=%0d done_at=%0d expected 4/1/4", nwin, ndone, done_win);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i < nwin && win_pix[i] != exp_pix[i]) begin
        n_fail++;
        $display("FAIL continuous_latency win%0d: got pixel %0d expected %0d", i, win_pix[i], exp_pix[i]);
      end
    end
  endtask

  task automatic test_gaps();
    int nwin = 0;
    for (int i = 0; i < 16; i++) begin
      push(1'b1, i == 0, DW'(i));
      if (i != 15) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) push(1'b0, 1'($urandom), DW'($urandom));
      end
    end
    foreach (q[k]) begin
      cycle(q[k].v, q[k].sof, q[k].d);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gaps cyc%0d: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (bus.win_valid === 1'b1) nwin++;
    end
    q.delete();
    n_tests++;
    if (nwin != 4) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d windows expected 4", nwin);
    end
  endtask

  task automatic test_reset_abort();
    int nwin = 0;
    logic [VW-1:0] zero;
    zero = '0;
    for (int i = 0; i < 10; i++) cycle(1'b1, i == 0, DW'(i));
    do_reset();
    n_tests++;
    if (got_vec() !== zero) begin
      n_fail++;
      $display("FAIL abort_reset_state: got %h expected %h", got_vec(), zero);
    end
    for (int i = 10; i < 16; i++) push(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 16; i++) push(1'b1, i == 0, DW'(15 - i));
    foreach (q[k]) begin
      cycle(q[k].v, q[k].sof, q[k].d);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL abort cyc%0d: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (bus.win_valid === 1'b1) nwin++;
    end
    q.delete();
    n_tests++;
    if (nwin != 4) begin
      n_fail++;
      $display("FAIL abort_count: got %0d windows expected 4", nwin);
    end
  endtask

  task automatic test_sof_restart();
    int nwin = 0;
    for (int i = 0; i < 5; i++) push(1'b1, i == 0, DW'($urandom));
    for (int i = 0; i < 16; i++) push(1'b1, i == 0, DW'($urandom));
    foreach (q[k]) begin
      cycle(q[k].v, q[k].sof, q[k].d);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sof_restart cyc%0d: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (bus.win_valid === 1'b1) nwin++;
    end
    q.delete();
    n_tests++;
    if (nwin != 4) begin
      n_fail++;
      $display("FAIL sof_restart_count: got %0d windows expected 4", nwin);
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0, ndone = 0;
    int done_at [2] = '{0, 0};
    for (int i = 0; i < 16; i++) push(1'b1, i == 0, DW'(4'h8));
    for (int i = 0; i < 16; i++) push(1'b1, 1'b0, DW'(4'h7));
    foreach (q[k]) begin
      cycle(q[k].v, q[k].sof, q[k].d);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.frame_done === 1'b1) begin
        if (ndone < 2) done_at[ndone] = nwin;
        ndone++;
      end
    end
    q.delete();
    n_tests++;
    if (nwin != 8 || ndone != 2 || done_at[0] != 4 || done_at[1] != 8) begin
      n_fail++;
      $display("FAIL back_to_back_counts: got win=%0d done=%0d at %0d,%0d expected 8/2 at 4,8",
               nwin, ndone, done_at[0], done_at[1]);
    end
  endtask

  task automatic test_random_frames();
    int nwin = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        push(1'b1, i == 0, DW'($urandom));
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) push(1'b0, 1'($urandom), DW'($urandom));
      end
    end
    foreach (q[k]) begin
      cycle(q[k].v, q[k].sof, q[k].d);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (bus.win_valid === 1'b1) nwin++;
    end
    q.delete();
    n_tests++;
    if (nwin != 12) begin
      n_fail++;
      $display("FAIL random_count: got %0d windows expected 12", nwin);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    model_reset();
    test_reset();
    test_continuous();
    test_gaps();
    test_reset_abort();
    test_sof_restart();
    test_back_to_back();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
